// File: rtl/tab_hash_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tab_hash_pkg
// Description : Shared constants, FSM state type and rotate helper for the
//               eight-lane tabulation hash engine.
// Revision    : 1.0 - initial release
// ============================================================================
package tab_hash_pkg;

    localparam int NUM_HASH  = 8;
    localparam int MAX_DBITS = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rotate the low 'width' bits of value left by 'amount'; upper bits are zeroed.
    function automatic logic [MAX_DBITS-1:0] rotl(
        input logic [MAX_DBITS-1:0] value,
        input int unsigned          amount,
        input int unsigned          width
    );
        logic [MAX_DBITS-1:0] mask;
        logic [MAX_DBITS-1:0] v;
        int unsigned          sh;
        mask = {MAX_DBITS{1'b1}} >> (MAX_DBITS - width);
        sh   = amount % width;
        v    = value & mask;
        rotl = ((v << sh) | (v >> (width - sh))) & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tab_hash_lane.sv
`default_nettype none
// ============================================================================
// Module      : tab_hash_lane
// Description : One hash accumulator: loads an init value, then XORs in a
//               rotated table lane on every update cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tab_hash_lane
    import tab_hash_pkg::*;
#(
    parameter int DBITS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             update,
    input  logic [DBITS-1:0] init,
    input  logic [DBITS-1:0] lane_data,
    input  logic [31:0]      rot_amt,
    output logic [DBITS-1:0] acc
);

    logic [MAX_DBITS-1:0] w_rot_full;
    logic [DBITS-1:0]     w_rot;
    logic [DBITS-1:0]     r_acc;

    assign w_rot_full = rotl(MAX_DBITS'(lane_data), rot_amt, DBITS);
    assign w_rot      = w_rot_full[DBITS-1:0];
    assign acc        = r_acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= init;
        end else if (update) begin
            r_acc <= r_acc ^ w_rot;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tab_hash8_engine.sv
`default_nettype none
// ============================================================================
// Module      : tab_hash8_engine
// Description : Byte-serial tabulation hash producing eight DBITS hashes per
//               key from an external 8-output table. Optional macro
//               TAB_HASH_SEED_EN loads accumulators with SEED instead of 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tab_hash8_engine
    import tab_hash_pkg::*;
#(
    parameter int               KEY_BYTES = 4,
    parameter int               DBITS     = 32,
    parameter logic [DBITS-1:0] SEED      = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*KEY_BYTES-1:0]  in_key,
    output logic [7:0]              tbl_addr,
    input  logic [8*DBITS-1:0]      tbl_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DBITS-1:0]      out_hash
);

    localparam int IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

`ifdef TAB_HASH_SEED_EN
    localparam logic [DBITS-1:0] c_init = SEED;
`else
    // SEED is intentionally discarded when seeding is not built in.
    localparam logic [DBITS-1:0] c_init = SEED & {DBITS{1'b0}};
`endif

    state_t                 r_state;
    state_t                 w_next_state;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [IDX_W-1:0]       r_index;
    logic                   w_accept;
    logic                   w_running;
    logic                   w_last;
    logic [7:0]             w_key_byte;
    logic [31:0]            w_rot_amt;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_running = (r_state == RUN);
    assign w_last    = (r_index == IDX_W'(KEY_BYTES - 1));
    assign w_rot_amt = (32'(r_index) * 32'd8) % 32'(DBITS);

    always_comb begin
        w_key_byte = 8'h00;
        for (int i = 0; i < KEY_BYTES; i++) begin
            if (r_index == IDX_W'(i)) begin
                w_key_byte = r_key[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    // Address comes only from the latched key so there is no in_key -> tbl_addr path.
    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
        tbl_addr  = w_running ? w_key_byte : 8'h00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key   <= '0;
            r_index <= '0;
        end else if (w_accept) begin
            r_key   <= in_key;
            r_index <= '0;
        end else if (w_running) begin
            r_index <= w_last ? '0 : r_index + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_HASH; k++) begin : g_lane
        tab_hash_lane #(
            .DBITS (DBITS)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load      (w_accept),
            .update    (w_running),
            .init      (c_init),
            .lane_data (tbl_data[DBITS*k +: DBITS]),
            .rot_amt   (w_rot_amt),
            .acc       (out_hash[DBITS*k +: DBITS])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_tab_hash8_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_tab_hash8_engine
// Description : Self-checking bench for tab_hash8_engine with an identity
//               table (entry[a] = a) and a byte-wise reference hash model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tab_hash8_engine;

    localparam int          KEY_BYTES = 4;
    localparam int          DBITS     = 32;
    localparam logic [31:0] SEED_VAL  = 32'hFFFF_FFFF;
`ifdef TAB_HASH_SEED_EN
    localparam logic [31:0] c_seed = SEED_VAL;
`else
    localparam logic [31:0] c_seed = 32'h0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_key = 32'h0;
    logic [7:0]   tbl_addr;
    logic [255:0] tbl_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_hash;

    int checks = 0;
    int errors = 0;
    logic [7:0] addr_q[$];

    always #5 clk = ~clk;

    // Identity table: lane k returns entry (addr + k) mod 256.
    always_comb begin
        tbl_data = '0;
        for (int k = 0; k < 8; k++) begin
            tbl_data[32*k +: 32] = {24'd0, 8'(tbl_addr + 8'(k))};
        end
    end

    tab_hash8_engine #(
        .KEY_BYTES (KEY_BYTES),
        .DBITS     (DBITS),
        .SEED      (SEED_VAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash)
    );

    // hash_k = seed XOR over bytes i of rotl(table[byte_i + k], 8*i)
    function automatic logic [31:0] ref_hash(input logic [31:0] key, input int k);
        logic [31:0] acc;
        logic [31:0] v;
        logic [63:0] d;
        int          s;
        acc = c_seed;
        for (int i = 0; i < KEY_BYTES; i++) begin
            v   = 32'((int'(key[8*i +: 8]) + k) % 256);
            s   = (8 * i) % 32;
            d   = {v, v} >> (32 - s);
            acc = acc ^ d[31:0];
        end
        return acc;
    endfunction

    task automatic send_key(input logic [31:0] key, input string tag);
        int n;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", tag, in_ready);
        end
        in_valid = 1'b1;
        in_key   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_key   = $urandom;
        n = 0;
        addr_q.delete();
        while (out_valid !== 1'b1 && n < 50) begin
            addr_q.push_back(tbl_addr);
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != KEY_BYTES) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, KEY_BYTES);
        end
        for (int i = 0; i < KEY_BYTES && i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== key[8*i +: 8]) begin
                errors++;
                $display("FAIL %s tbl_addr[%0d]: got %h want %h", tag, i, addr_q[i], key[8*i +: 8]);
            end
        end
    endtask

    task automatic check_hashes(input logic [31:0] key, input string tag);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (out_hash[32*k +: 32] !== ref_hash(key, k)) begin
                errors++;
                $display("FAIL %s hash_%0d: got %h want %h", tag, k, out_hash[32*k +: 32], ref_hash(key, k));
            end
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s handshake: got valid=%b ready=%b want valid=0 ready=1", tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || tbl_addr !== 8'h00 || out_hash !== 256'h0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b addr=%h hash=%h want 1 0 00 0",
                     in_ready, out_valid, tbl_addr, out_hash);
        end
        reset = 1'b0;
    endtask

    task automatic test_known_vectors();
        send_key(32'h0000_0000, "key0");
        check_hashes(32'h0000_0000, "key0");
        checks++;
        if (c_seed == 32'h0 && out_hash[32*1 +: 32] !== 32'h0101_0101) begin
            errors++;
            $display("FAIL key0_literal hash_1: got %h want 01010101", out_hash[63:32]);
        end else if (c_seed != 32'h0 && out_hash[32*1 +: 32] !== 32'hFEFE_FEFE) begin
            errors++;
            $display("FAIL seed_literal hash_1: got %h want fefefefe", out_hash[63:32]);
        end
        release_out("key0");
        send_key(32'h0000_0005, "key5");
        check_hashes(32'h0000_0005, "key5");
        release_out("key5");
    endtask

    task automatic test_random();
        logic [31:0] key;
        for (int t = 0; t < 20; t++) begin
            key = $urandom;
            send_key(key, "rand");
            check_hashes(key, "rand");
            repeat ($urandom_range(0, 3)) begin
                in_valid = $urandom_range(0, 1);
                in_key   = $urandom;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            check_hashes(key, "rand_hold");
            release_out("rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] saved;
        logic [31:0]  key_a;
        logic [31:0]  key_b;
        int           n;
        key_a = $urandom;
        key_b = $urandom;
        send_key(key_a, "stall");
        saved    = out_hash;
        in_valid = 1'b1;
        in_key   = key_b;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_hash !== saved || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d: got hash=%h ready=%b valid=%b want hash=%h ready=0 valid=1",
                         c, out_hash, in_ready, out_valid, saved);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got ready=%b valid=%b want ready=1 valid=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_next_accept: got ready=%b want 0", in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != KEY_BYTES) begin
            errors++;
            $display("FAIL stall_next_latency: got %0d want %0d", n, KEY_BYTES);
        end
        check_hashes(key_b, "stall_next");
        release_out("stall_next");
    endtask

    task automatic test_reset_midrun();
        in_valid = 1'b1;
        in_key   = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || tbl_addr !== 8'h00 || out_hash !== 256'h0) begin
            errors++;
            $display("FAIL midrun_reset: got valid=%b ready=%b addr=%h hash=%h want 0 1 00 0",
                     out_valid, in_ready, tbl_addr, out_hash);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        send_key(32'h0000_0000, "after_reset");
        check_hashes(32'h0000_0000, "after_reset");
        release_out("after_reset");
    endtask

    initial begin
        test_reset();
        test_known_vectors();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
